repl_policy_set: RTL and testbench

- Parametrised per-set replacement-way generator for the set-associative I/D caches.
- Holds replacement state for every set and supports SET_ASSOC from 2 to 16 (power of 2).
- Policy is selected at elaboration: FIFO, tree pseudo-LRU or LFSR random.
- Chooses invalid ways first. Updated on hits and fills from the cache controller FSM.

---
 rtl/repl_policy_set_if.sv | 29 ++
 rtl/repl_policy_set.sv | 177 +++++++++++++++++
 tb/tb_repl_policy_set.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/repl_policy_set_if.sv
// Lookup/update bus between the cache controller and the per-set
// replacement-way generator.
//   master : cache controller (drives lookup and update, reads the victim way)
//   slave  : repl_policy_set
interface repl_policy_set_if #(
    parameter int SET_ASSOC = 4,
    parameter int NUM_SETS  = 64
);
    localparam int IW = $clog2(SET_ASSOC);
    localparam int SW = $clog2(NUM_SETS);

    logic [SW-1:0]        lkp_set;
    logic [SET_ASSOC-1:0] lkp_valid;
    logic [IW-1:0]        repl_index;
    logic                 upd_en;
    logic [SW-1:0]        upd_set;
    logic [IW-1:0]        upd_way;
    logic                 upd_fill;

    modport master (
        output lkp_set, lkp_valid, upd_en, upd_set, upd_way, upd_fill,
        input  repl_index
    );

    modport slave (
        input  lkp_set, lkp_valid, upd_en, upd_set, upd_way, upd_fill,
        output repl_index
    );
endinterface

// File: rtl/repl_policy_set.sv
// Per-set replacement-way generator for the set-associative caches.
// POLICY: 0 = FIFO victim pointer, 1 = tree pseudo-LRU, 2 = LFSR random.
// Invalid ways are always chosen first (lowest invalid index).
// Optional macro REPL_BYPASS_EN: a same-cycle update to the looked-up set
// is forwarded into repl_index (write-before-read). Without it the lookup
// sees the state as it was before this cycle's update.
module repl_policy_set #(
    parameter int          SET_ASSOC = 4,
    parameter int          NUM_SETS  = 64,
    parameter int          POLICY    = 1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    repl_policy_set_if.slave bus
);
    localparam int IW = $clog2(SET_ASSOC);
    localparam int TW = SET_ASSOC - 1;

    logic          inv_found_s;
    logic [IW-1:0] inv_idx_s;
    logic [IW-1:0] policy_idx_s;

    // Walk the heap-ordered tree from the root; a 0 bit means go left.
    function automatic logic [IW-1:0] plru_victim(input logic [TW-1:0] t);
        int node;
        node = 0;
        for (int l = 0; l < IW; l++) begin
            node = 2 * node + 1 + int'(t[node]);
        end
        return IW'(node - TW);
    endfunction

    // Make every node on the path to way w point away from w.
    function automatic logic [TW-1:0] plru_touch(input logic [TW-1:0] t,
                                                 input logic [IW-1:0] w);
        logic [TW-1:0] r;
        logic          d;
        int            node;
        r    = t;
        node = 0;
        for (int l = 0; l < IW; l++) begin
            d       = w[IW-1-l];
            r[node] = ~d;
            node    = 2 * node + 1 + int'(d);
        end
        return r;
    endfunction

    // Lowest-index invalid way, scanned from the top so the lowest wins.
    always_comb begin
        inv_found_s = 1'b0;
        inv_idx_s   = '0;
        for (int i = SET_ASSOC - 1; i >= 0; i--) begin
            if (!bus.lkp_valid[i]) begin
                inv_found_s = 1'b1;
                inv_idx_s   = IW'(i);
            end else begin
                inv_found_s = inv_found_s;
            end
        end
    end

    generate
        if (POLICY == 0) begin : g_fifo
            logic [IW-1:0] ptr_q [NUM_SETS];
            logic [IW-1:0] ptr_d;

            // Victim pointer after a fill: the way following the filled one.
            always_comb begin
                ptr_d = bus.upd_way + IW'(1);
            end

            // Pointer array: cleared on reset, advanced on fills only.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int s = 0; s < NUM_SETS; s++) begin
                        ptr_q[s] <= '0;
                    end
                end else if (bus.upd_en && bus.upd_fill) begin
                    ptr_q[bus.upd_set] <= ptr_d;
                end
            end

            // Victim from the looked-up set's pointer.
            always_comb begin
`ifdef REPL_BYPASS_EN
                if (bus.upd_en && bus.upd_fill && (bus.upd_set == bus.lkp_set)) begin
                    policy_idx_s = ptr_d;
                end else begin
                    policy_idx_s = ptr_q[bus.lkp_set];
                end
`else
                policy_idx_s = ptr_q[bus.lkp_set];
`endif
            end
        end else if (POLICY == 1) begin : g_plru
            logic [TW-1:0] tree_q [NUM_SETS];
            logic [TW-1:0] tree_d;

            // Next tree for the set being accessed.
            always_comb begin
                tree_d = plru_touch(tree_q[bus.upd_set], bus.upd_way);
            end

            // Tree array: cleared on reset, touched on hits and fills.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int s = 0; s < NUM_SETS; s++) begin
                        tree_q[s] <= '0;
                    end
                end else if (bus.upd_en) begin
                    tree_q[bus.upd_set] <= tree_d;
                end
            end

            // Victim from the looked-up set's tree.
            always_comb begin
`ifdef REPL_BYPASS_EN
                if (bus.upd_en && (bus.upd_set == bus.lkp_set)) begin
                    policy_idx_s = plru_victim(tree_d);
                end else begin
                    policy_idx_s = plru_victim(tree_q[bus.lkp_set]);
                end
`else
                policy_idx_s = plru_victim(tree_q[bus.lkp_set]);
`endif
            end
        end else if (POLICY == 2) begin : g_rand
            logic [15:0] lfsr_q;
            logic [15:0] lfsr_d;

            // Fibonacci LFSR, taps 16,14,13,11 in right-shift form
            // (bits 0,2,3,5 feed the new MSB).
            always_comb begin
                lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
            end

            // Shared LFSR: seeded on reset, free-running otherwise.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    lfsr_q <= LFSR_SEED;
                end else begin
                    lfsr_q <= lfsr_d;
                end
            end

            // Victim from the low LFSR bits.
            always_comb begin
`ifdef REPL_BYPASS_EN
                policy_idx_s = lfsr_d[IW-1:0];
`else
                policy_idx_s = lfsr_q[IW-1:0];
`endif
            end
        end else begin : g_bad_policy
            $error("repl_policy_set: POLICY must be 0, 1 or 2");
            assign policy_idx_s = '0;
        end

        if ((SET_ASSOC < 2) || (SET_ASSOC > 16) || ((1 << IW) != SET_ASSOC)) begin : g_bad_assoc
            $error("repl_policy_set: SET_ASSOC must be a power of 2 in 2..16");
        end
        if (LFSR_SEED == 16'h0000) begin : g_bad_seed
            $error("repl_policy_set: LFSR_SEED must be non-zero");
        end
    endgenerate

    // Invalid ways take priority over the policy's choice.
    always_comb begin
        if (inv_found_s) begin
            bus.repl_index = inv_idx_s;
        end else begin
            bus.repl_index = policy_idx_s;
        end
    end
endmodule

// File: tb/tb_repl_policy_set.sv
// Directed bench for repl_policy_set: PLRU (4-way), FIFO (8-way) and
// random (4-way) instances share one clock and reset.
module tb_repl_policy_set;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;
    logic [15:0] lfsr_m;

    repl_policy_set_if #(.SET_ASSOC(4), .NUM_SETS(64)) if_plru ();
    repl_policy_set_if #(.SET_ASSOC(8), .NUM_SETS(64)) if_fifo ();
    repl_policy_set_if #(.SET_ASSOC(4), .NUM_SETS(64)) if_rnd ();

    repl_policy_set #(.SET_ASSOC(4), .NUM_SETS(64), .POLICY(1), .LFSR_SEED(16'hACE1))
        u_plru (.clk(clk), .rst_n(rst_n), .bus(if_plru));
    repl_policy_set #(.SET_ASSOC(8), .NUM_SETS(64), .POLICY(0), .LFSR_SEED(16'hACE1))
        u_fifo (.clk(clk), .rst_n(rst_n), .bus(if_fifo));
    repl_policy_set #(.SET_ASSOC(4), .NUM_SETS(64), .POLICY(2), .LFSR_SEED(16'hACE1))
        u_rnd  (.clk(clk), .rst_n(rst_n), .bus(if_rnd));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Advance one active edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference LFSR: bit = s0^s2^s3^s5 enters at the top on a right shift.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        if_plru.lkp_set = 6'd0; if_plru.lkp_valid = 4'b1111;
        if_plru.upd_en = 1'b0; if_plru.upd_set = 6'd0; if_plru.upd_way = 2'd0; if_plru.upd_fill = 1'b0;
        if_fifo.lkp_set = 6'd0; if_fifo.lkp_valid = 8'hFF;
        if_fifo.upd_en = 1'b0; if_fifo.upd_set = 6'd0; if_fifo.upd_way = 3'd0; if_fifo.upd_fill = 1'b0;
        if_rnd.lkp_set = 6'd0; if_rnd.lkp_valid = 4'b1111;
        if_rnd.upd_en = 1'b0; if_rnd.upd_set = 6'd0; if_rnd.upd_way = 2'd0; if_rnd.upd_fill = 1'b0;

        tick();
        tick();
        rst_n = 1'b1;

        // Reset state: every PLRU set and every FIFO set points at way 0.
        for (int s = 0; s < 64; s++) begin
            if_plru.lkp_set = 6'(s);
            if_fifo.lkp_set = 6'(s);
            #1;
            check_eq($sformatf("plru_reset_set%0d", s), int'(if_plru.repl_index), 0);
            check_eq($sformatf("fifo_reset_set%0d", s), int'(if_fifo.repl_index), 0);
        end

        // Invalid-first.
        if_plru.lkp_set = 6'd0;
        if_plru.lkp_valid = 4'b1011; #1;
        check_eq("inv_first_1011", int'(if_plru.repl_index), 2);
        if_plru.lkp_valid = 4'b0000; #1;
        check_eq("inv_first_0000", int'(if_plru.repl_index), 0);
        if_plru.lkp_valid = 4'b0111; #1;
        check_eq("inv_first_0111", int'(if_plru.repl_index), 3);
        if_fifo.lkp_valid = 8'b1010_1111; #1;
        check_eq("inv_first_fifo", int'(if_fifo.repl_index), 4);
        if_fifo.lkp_valid = 8'hFF;
        if_plru.lkp_valid = 4'b1111;

        // PLRU set 5: hits 0,1,2,3 -> victim 0; hit 0 -> victim 2.
        if_plru.lkp_set = 6'd5;
        for (int w = 0; w < 4; w++) begin
            if_plru.upd_en = 1'b1; if_plru.upd_set = 6'd5;
            if_plru.upd_way = 2'(w); if_plru.upd_fill = 1'b0;
            tick();
        end
        if_plru.upd_en = 1'b0; #1;
        check_eq("plru_after_0123", int'(if_plru.repl_index), 0);
        if_plru.upd_en = 1'b1; if_plru.upd_way = 2'd0;
        tick();
        if_plru.upd_en = 1'b0; #1;
        check_eq("plru_after_hit0", int'(if_plru.repl_index), 2);
        if_plru.lkp_set = 6'd6; #1;
        check_eq("plru_set6_untouched", int'(if_plru.repl_index), 0);

        // Same-set collision on set 2 (state 0): hit way 0 while looking up set 2.
        if_plru.lkp_set = 6'd2;
        if_plru.upd_en = 1'b1; if_plru.upd_set = 6'd2;
        if_plru.upd_way = 2'd0; if_plru.upd_fill = 1'b0;
        #1;
`ifdef REPL_BYPASS_EN
        check_eq("collision_same_cycle", int'(if_plru.repl_index), 2);
`else
        check_eq("collision_same_cycle", int'(if_plru.repl_index), 0);
`endif
        tick();
        if_plru.upd_en = 1'b0; #1;
        check_eq("collision_next_cycle", int'(if_plru.repl_index), 2);

        // FIFO set 3: fills to ways 0..7 step the pointer 1..7 then 0.
        if_fifo.lkp_set = 6'd3;
        for (int w = 0; w < 8; w++) begin
            if_fifo.upd_en = 1'b1; if_fifo.upd_set = 6'd3;
            if_fifo.upd_way = 3'(w); if_fifo.upd_fill = 1'b1;
            tick();
            if_fifo.upd_en = 1'b0; #1;
            check_eq($sformatf("fifo_fill_way%0d", w), int'(if_fifo.repl_index), (w + 1) % 8);
        end
        if_fifo.upd_en = 1'b1; if_fifo.upd_way = 3'd4; if_fifo.upd_fill = 1'b0;
        tick();
        if_fifo.upd_en = 1'b0; #1;
        check_eq("fifo_hit_no_change", int'(if_fifo.repl_index), 0);
        if_fifo.lkp_set = 6'd4; #1;
        check_eq("fifo_set4_untouched", int'(if_fifo.repl_index), 0);

        // Random: restart from the seed, 4 cycles, reset pulse, 4 more cycles.
        #1;
        rst_n = 1'b0;
        tick();
        rst_n  = 1'b1;
        lfsr_m = 16'hACE1;
        for (int c = 0; c < 8; c++) begin
            if (c == 4) begin
                rst_n = 1'b0;
                tick();
                rst_n  = 1'b1;
                lfsr_m = 16'hACE1;
            end else begin
                lfsr_m = lfsr_m;
            end
            #1;
`ifdef REPL_BYPASS_EN
            check_eq($sformatf("rand_cycle%0d", c), int'(if_rnd.repl_index), int'(lfsr_step(lfsr_m) & 16'h0003));
`else
            check_eq($sformatf("rand_cycle%0d", c), int'(if_rnd.repl_index), int'(lfsr_m & 16'h0003));
`endif
            tick();
            lfsr_m = lfsr_step(lfsr_m);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
